// File: rtl/divu_seq_pkg.sv
// Shared ALU package for the HI/LO datapath.
// Holds the opcode values on the 6-bit `signal` bus (shared with the MULTU
// multiplier), the sequencer state encoding and the HI/LO field positions
// inside the 64-bit result word.
package divu_seq_pkg;

  // Opcodes on the `signal` bus. Any other code is a no-op.
  localparam logic [5:0] SIG_MULTU = 6'b011001;
  localparam logic [5:0] SIG_DIVU  = 6'b011011;
  localparam logic [5:0] SIG_OUT   = 6'b111111;

  // MIPS HI/LO layout of the 64-bit result word.
  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divu_seq_step.sv
// divu_step: one combinational iteration of restoring unsigned division.
// Ports:
//   rem       partial remainder before this iteration
//   quot      dividend/quotient shift register before this iteration
//   divisor   divisor latched at start
//   rem_next  partial remainder after this iteration
//   quot_next quotient register after this iteration (new bit enters at [0])
module divu_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quot_next
);

  // The remainder can reach 2*divisor-1 after the shift, so both the shifted
  // value and the trial subtraction are one bit wider than the operands.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           fits;

  assign shifted = {rem, quot[WIDTH-1]};
  assign trial   = shifted - {1'b0, divisor};
  assign fits    = ~trial[WIDTH];

  assign rem_next  = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quot_next = {quot[WIDTH-2:0], fits};

endmodule

// File: rtl/divu_seq.sv
// divu_seq: sequential 32-bit unsigned restoring divider, one quotient bit
// per clock. DIVU on `signal` starts a division, OUT publishes the result.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high
//   signal     opcode bus: DIVU starts, OUT publishes, anything else no-op
//   dataA      dividend, sampled on the start edge only
//   dataB      divisor, sampled on the start edge only
//   dataOut    registered {remainder (HI), quotient (LO)}
//   done       result ready and waiting for OUT
//   divByZero  divisor of the current/last operation was zero
module divu_seq
  import divu_seq_pkg::*;
#(
  parameter logic [5:0] DIVU  = SIG_DIVU,
  parameter logic [5:0] OUT   = SIG_OUT,
  parameter int         WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [2*WIDTH-1:0] dataOut,
  output logic             done,
  output logic             divByZero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state, state_next;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] rem, quot, divisor;
  logic [WIDTH-1:0] rem_next, quot_next;

  // Control strobes decoded from state and opcode.
  logic start, iterate, finish, publish;

  divu_step #(.WIDTH(WIDTH)) u_step (
    .rem       (rem),
    .quot      (quot),
    .divisor   (divisor),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // State register.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (signal == DIVU) state_next = RUN;
      RUN:  if (counter == LAST_ITER) state_next = DONE;
      DONE: begin
        if (signal == OUT)       state_next = IDLE;
        else if (signal == DIVU) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output/control decode. Opcodes are ignored while RUN is in progress.
  always_comb begin
    start   = 1'b0;
    iterate = 1'b0;
    finish  = 1'b0;
    publish = 1'b0;
    unique case (state)
      IDLE: start = (signal == DIVU);
      RUN: begin
        iterate = 1'b1;
        finish  = (counter == LAST_ITER);
      end
      DONE: begin
        publish = (signal == OUT);
        start   = (signal == DIVU);
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs.
  // NOTE: every register here, including the internal working registers, is
  // cleared by reset so an aborted division leaves no stale partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem       <= '0;
      quot      <= '0;
      divisor   <= '0;
      counter   <= '0;
      dataOut   <= '0;
      done      <= 1'b0;
      divByZero <= 1'b0;
    end else if (start) begin
      // A start in DONE discards the unread result.
      rem       <= '0;
      quot      <= dataA;
      divisor   <= dataB;
      counter   <= '0;
      done      <= 1'b0;
      divByZero <= (dataB == '0);
    end else if (iterate) begin
      rem     <= rem_next;
      quot    <= quot_next;
      counter <= counter + 1'b1;
      if (finish) done <= 1'b1;
    end else if (publish) begin
      dataOut[HI_MSB:HI_LSB] <= rem;
      dataOut[LO_MSB:LO_LSB] <= quot;
      done                   <= 1'b0;
    end
  end

endmodule

// File: doc/divu_seq.md
Name: divu_seq

Overview:
- Sequential 32-bit unsigned restoring divider: the inverse datapath of the shift-add MULTU unit in the ALU's HI/LO path.
- Driven by the same 6-bit `signal` opcode bus: DIVU starts an operation, OUT publishes the result.
- `dataOut` follows the MIPS HI/LO layout: {remainder, quotient}.
- One quotient bit per clock.

Parameters:
- DIVU, 6'b011011, signal code that starts a division
- OUT, 6'b111111, signal code that publishes the result to `dataOut`
- WIDTH, 32, operand width; only 32 is required and verified

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high
- signal  in  6  opcode: DIVU, OUT, anything else = no-op
- dataA  in  32  dividend, sampled only on the start edge
- dataB  in  32  divisor, sampled only on the start edge
- dataOut  out  64  [63:32] remainder (HI), [31:0] quotient (LO); registered
- done  out  1  result ready, waiting for OUT
- divByZero  out  1  divisor was 0 for the current/last operation

Behaviour:
- Reset values (async, immediate): dataOut=0, done=0, divByZero=0, state=IDLE, counter=0. Internal rem/quot/divisor registers are cleared to 0.
- State IDLE:
  - signal==DIVU at an edge: latch quot=dataA, divisor=dataB, rem=0, counter=0; set divByZero=(dataB==0); go to RUN.
  - Any other code: no change. OUT in IDLE does not touch dataOut.
- State RUN: one iteration per edge, independent of `signal`.
  - Step 1: shift {rem,quot} left 1, giving a 33-bit shifted rem.
  - Step 2: trial = shifted rem − {1'b0,divisor}, computed 33-bit.
  - If trial[32]==0: rem=trial[31:0], quot[0]=1. Otherwise rem=shifted rem, quot[0]=0.
  - counter increments each iteration.
  - On the edge performing iteration 32 (counter==31): go to DONE and set done=1.
  - DIVU or OUT during RUN is ignored: no restart, and dataOut is unchanged.
- State DONE: done held high.
  - OUT at an edge: dataOut={rem,quot}, done=0, go to IDLE.
  - DIVU at an edge: unread result discarded, done=0, restart exactly as from IDLE with new operands.
  - Other codes: hold.
- Latency: DIVU sampled at edge E0, done high after edge E32. The earliest OUT at E33 makes dataOut valid after E33.
- Divide by zero: no special datapath. The algorithm naturally yields quot=32'hFFFFFFFF and rem=dataA; divByZero flags it.
- divByZero is updated only on a start edge and held until the next start or reset.
- dataOut holds its value until the next accepted OUT or reset.
- Reset mid-operation: abort immediately, all outputs return to reset values, and no partial result ever appears on dataOut.
- Arithmetic: strictly unsigned. Dividend < divisor gives quot=0, rem=dividend.

Decomposition:
- Shared ALU package:
  - signal opcode constants (MULTU 6'b011001, DIVU 6'b011011, OUT 6'b111111), shared with the multiplier
  - state enum {IDLE, RUN, DONE}
  - HI/LO field index constants
- Sub-module `divu_step`: combinational single iteration. Inputs rem, quot, divisor; outputs next rem, next quot. Keeps the FSM/counter separate from the datapath.

Test Plan:
1. dataA=100, dataB=7, DIVU for 1 cycle, wait for done, then OUT -> done high after edge 32; dataOut=64'h00000002_0000000E; divByZero=0.
2. dataA=32'hFFFFFFFF, dataB=1 -> dataOut=64'h00000000_FFFFFFFF. Then dataA=3, dataB=10 -> dataOut=64'h00000003_00000000.
3. dataA=5, dataB=0 -> divByZero=1 right after start edge; dataOut=64'h00000005_FFFFFFFF.
4. OUT asserted at cycles 5 and 20 of a RUN (dataA=32'h80000000, dataB=32'h80000000) -> dataOut stays at previous value; the final OUT gives 64'h00000000_00000001. Change dataA/dataB mid-RUN -> result unaffected.
5. reset pulsed at RUN cycle 10 -> all outputs 0 asynchronously. A new DIVU 9/4 then gives 64'h00000001_00000002.
6. In DONE, issue DIVU with 50/6 instead of OUT -> first result discarded; the later OUT gives 64'h00000002_00000008; done low during RUN.
